// File: rtl/cnt_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cnt_cfg_pkg
//   Shared constants and types for the configuration distributor
//   (cnt_cfg_dist) and its per-domain slice (cnt_cfg_slice).
//
//   CTR_NUMBER : number of counter clock domains; domain 0 is the master.
//   DATA_W     : width of one configuration word.
//   state_t    : master handshake FSM states.
// -----------------------------------------------------------------------------
package cnt_cfg_pkg;

   localparam int CTR_NUMBER = 8;
   localparam int DATA_W     = 10;

   // Master FSM: wait for a command, raise req, wait for every selected ack,
   // drop req, wait for every ack to fall, announce completion.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_REL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // True when every domain has either acknowledged or is not addressed.
   function automatic logic all_acked(input logic [CTR_NUMBER-1:0] ack,
                                      input logic [CTR_NUMBER-1:0] mask);
      return &(ack | ~mask);
   endfunction

   // True when no addressed domain still holds its ack high.
   function automatic logic all_released(input logic [CTR_NUMBER-1:0] ack,
                                         input logic [CTR_NUMBER-1:0] mask);
      return ~|(ack & mask);
   endfunction

endpackage : cnt_cfg_pkg

// File: rtl/cnt_cfg_slice.sv
// -----------------------------------------------------------------------------
// cnt_cfg_slice
//   One destination domain of the configuration distributor. Synchronises the
//   request level from the master domain, captures the held word on the
//   request's rising edge, emits a one-cycle write strobe and returns the
//   synchronised request as the acknowledge.
//
// Ports
//   clock        in   1       destination domain clock
//   rst          in   1       asynchronous active-low reset
//   i_req        in   1       request level from the master domain (async)
//   i_hold_data  in   DATA_W  word held stable by the master while req is up
//   o_ack        out  1       acknowledge level back to the master domain
//   o_data       out  DATA_W  last delivered word
//   o_wr         out  1       one-cycle strobe when o_data is updated
// -----------------------------------------------------------------------------
module cnt_cfg_slice
   import cnt_cfg_pkg::*;
(
   input  logic              clock,
   input  logic              rst,
   input  logic              i_req,
   input  logic [DATA_W-1:0] i_hold_data,
   output logic              o_ack,
   output logic [DATA_W-1:0] o_data,
   output logic              o_wr
);

   logic [1:0]        r_req_s;   // 2-FF synchroniser, [1] is the safe tap
   logic              r_req_d;   // previous synchronised request, for edge detect
   logic              r_ack;
   logic              r_wr;
   logic [DATA_W-1:0] r_data;
   logic              w_req_rise;

   assign w_req_rise = r_req_s[1] & ~r_req_d;

   // NOTE: every register here, data included, is cleared by reset; the
   // delivered word must read 0 after reset, so r_data is not left unreset.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         r_req_s <= 2'b00;
         r_req_d <= 1'b0;
         r_ack   <= 1'b0;
         r_wr    <= 1'b0;
         r_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments give every flop the pre-edge value
         // of its source, which is what makes the shift chain a synchroniser.
         r_req_s <= {r_req_s[0], i_req};
         r_req_d <= r_req_s[1];
         r_ack   <= r_req_s[1];
         r_wr    <= w_req_rise;
         // i_hold_data is quasi-static: the master does not change it from
         // raising req until the whole four-phase cycle has closed, so a
         // multi-bit sample taken two flops after req is coherent.
         if (w_req_rise) begin
            r_data <= i_hold_data;
         end
      end
   end

   assign o_ack  = r_ack;
   assign o_data = r_data;
   assign o_wr   = r_wr;

endmodule : cnt_cfg_slice

// File: rtl/cnt_cfg_dist.sv
// -----------------------------------------------------------------------------
// cnt_cfg_dist
//   Broadcasts one configuration word per transfer from the clocks[0] domain
//   into every selected counter clock domain using a closed-loop four-phase
//   req/ack handshake per domain.
//
// Ports
//   clocks       in   CTR_NUMBER           per-domain clocks, [0] = master
//   rst          in   1                    asynchronous active-low reset
//   i_cmd_data   in   DATA_W               word to broadcast (clocks[0])
//   i_cmd_mask   in   CTR_NUMBER           destination select (clocks[0])
//   i_cmd_valid  in   1                    command offered (clocks[0])
//   o_cmd_ready  out  1                    idle, command will be accepted
//   o_busy       out  1                    transfer in progress
//   o_done       out  1                    one-cycle completion pulse
//   o_out_data   out  CTR_NUMBER x DATA_W  per-domain word, in clocks[i]
//   o_out_wr     out  CTR_NUMBER           per-domain write strobe, clocks[i]
// -----------------------------------------------------------------------------
module cnt_cfg_dist
   import cnt_cfg_pkg::*;
(
   input  logic [CTR_NUMBER-1:0]             clocks,
   input  logic                              rst,
   input  logic [DATA_W-1:0]                 i_cmd_data,
   input  logic [CTR_NUMBER-1:0]             i_cmd_mask,
   input  logic                              i_cmd_valid,
   output logic                              o_cmd_ready,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [CTR_NUMBER-1:0][DATA_W-1:0] o_out_data,
   output logic [CTR_NUMBER-1:0]             o_out_wr
);

   // ---------------------------------------------------------------------
   // Master domain state
   // ---------------------------------------------------------------------
   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_req;
   logic                    w_req_nxt;
   logic                    w_accept;
   logic [DATA_W-1:0]       r_hold_data;
   logic [CTR_NUMBER-1:0]   r_hold_mask;
   logic [CTR_NUMBER-1:0]   r_ack_meta;
   logic [CTR_NUMBER-1:0]   r_ack_sync;

   // Per-domain request and acknowledge levels
   logic [CTR_NUMBER-1:0]   w_req_dom;
   logic [CTR_NUMBER-1:0]   w_ack;

   // ---------------------------------------------------------------------
   // FSM next-state and control decode
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block is given a default first, so no
      // path through the case statement can leave one unassigned (no latch).
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_accept    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (i_cmd_valid) begin
               w_accept    = 1'b1;
               w_req_nxt   = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            // Unselected domains count as acknowledged, so a zero mask
            // falls straight through.
            if (all_acked(r_ack_sync, r_hold_mask)) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = S_REL;
            end
         end
         S_REL: begin
            // Waiting for acks to fall closes the loop: the next request
            // edge cannot be merged with this one in a slow domain.
            if (all_released(r_ack_sync, r_hold_mask)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Master domain registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clocks[0] or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_req       <= 1'b0;
         r_hold_data <= '0;
         r_hold_mask <= '0;
         r_ack_meta  <= '0;
         r_ack_sync  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= w_req_nxt;
         r_ack_meta <= w_ack;
         r_ack_sync <= r_ack_meta;
         // Hold registers load only on acceptance and therefore stay frozen
         // until the FSM is back in S_IDLE.
         if (w_accept) begin
            r_hold_data <= i_cmd_data;
            r_hold_mask <= i_cmd_mask;
         end
      end
   end

   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_DONE);

   // Qualify the shared request per domain in the master domain, so each
   // slice sees a single registered-source level to synchronise.
   assign w_req_dom = {CTR_NUMBER{r_req}} & r_hold_mask;

   // ---------------------------------------------------------------------
   // Destination slices; domain 0 takes the same synchronised path.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < CTR_NUMBER; gi++) begin : g_slice
      cnt_cfg_slice u_slice (
         .clock       (clocks[gi]),
         .rst         (rst),
         .i_req       (w_req_dom[gi]),
         .i_hold_data (r_hold_data),
         .o_ack       (w_ack[gi]),
         .o_data      (o_out_data[gi]),
         .o_wr        (o_out_wr[gi])
      );
   end

endmodule : cnt_cfg_dist

// File: doc/cnt_cfg_dist.md
# cnt_cfg_dist

Broadcasts one configuration word per transfer from the clocks[0] domain into each of CTR_NUMBER counter clock domains. Typical words are preload or threshold values for the integer/fractional counters. Each transfer uses a four-phase req/ack handshake per destination domain. The block is the downstream counterpart of the counter-to-master collector and sits between the control logic in the clocks[0] domain and the per-channel counters.

## Interface
- CTR_NUMBER, 8, number of counter clock domains.
- DATA_W, 10, configuration word width.
- clocks  in  CTR_NUMBER  per-channel clocks; clocks[0] is the master/control domain.
- rst  in  1  reset, asynchronous, active-low, common to all domains.
- cmd_data  in  DATA_W  word to broadcast (clocks[0]).
- cmd_mask  in  CTR_NUMBER  destination select; bit i = deliver to domain i (clocks[0]).
- cmd_valid  in  1  command offered (clocks[0]).
- cmd_ready  out  1  block idle and accepting (clocks[0]).
- busy  out  1  transfer in progress (clocks[0]).
- done  out  1  one-cycle pulse when all selected domains have completed the handshake (clocks[0]).
- out_data  out  DATA_W x CTR_NUMBER  per-domain delivered word, in clocks[i].
- out_wr  out  CTR_NUMBER  per-domain one-cycle write strobe, in clocks[i].

## Operation
- Master FSM in clocks[0] has four states: S_IDLE, S_REQ, S_REL, S_DONE. Reset state is S_IDLE.
- S_IDLE
  - cmd_ready=1.
  - On cmd_valid: latch cmd_data into hold_data and cmd_mask into hold_mask, set req_reg=1, go to S_REQ.
- S_REQ
  - Stay until (ack_sync | ~hold_mask) is all ones.
  - Then clear req_reg and go to S_REL.
- S_REL: stay until (ack_sync & hold_mask) is all zeros, then go to S_DONE.
- S_DONE: done=1 for one cycle, then go to S_IDLE.
- Derived outputs: busy = (state != S_IDLE); cmd_ready = (state == S_IDLE).
- hold_data and hold_mask stay stable from acceptance until S_IDLE is re-entered. This is what makes hold_data safe to sample from any domain.
- ack_sync[i] is a 2-FF synchronizer of ack[i] into clocks[0].
- Domain slice i, clocked by clocks[i]:
  - req_s: 2-FF synchronizer of req_reg & hold_mask[i].
  - req_d <= req_s[1].
  - ack[i] <= req_s[1].
  - On rising edge (req_s[1] & ~req_d): out_data[i] <= hold_data and out_wr[i] <= 1. Otherwise out_wr[i] <= 0.
- Slice 0 uses the same synchronizer path as the other slices; there is no bypass.
- Zero mask: the transfer is accepted and completes with a done pulse. No out_wr fires.
- cmd_valid outside S_IDLE is ignored; there is no queue.
- Reset mid-transfer (any state): all registers clear at once, the FSM returns to S_IDLE, and no out_wr fires.

## Timing
- Reset values:
  - cmd_ready=1, busy=0, done=0.
  - out_data[i]=0, out_wr[i]=0.
  - req_reg, ack, and all synchronizer registers = 0.
- Reference latency with all clocks identical, where the acceptance edge is edge 0:
  - req_reg=1 after edge 1.
  - out_wr/out_data valid after edge 4; out_wr low after edge 5.
  - FSM enters S_REL at edge 7.
  - done high after edge 13.
  - cmd_ready=1 after edge 14.
- With arbitrary clocks: out_wr[i] fires 3 to 4 clocks[i] edges after req_reg rises.
- out_wr[i] fires exactly once per transfer per selected domain.
- Frequency ratio between domains is unrestricted; the handshake is fully closed-loop.

## Structure
- Shared package cnt_cfg_pkg holds:
  - CTR_NUMBER and DATA_W;
  - the FSM state enum: S_IDLE, S_REQ, S_REL, S_DONE.
- Sub-module cnt_cfg_slice is one destination domain: synchronizer, edge detect, capture, ack. It is instantiated CTR_NUMBER times in a generate loop.
- The top level contains the master FSM, the hold registers, and the ack synchronizers.

## Test plan
- Identical clocks, cmd_data=0x2A5, cmd_mask=0xFF:
  - out_wr[i]=1 for exactly one cycle after edge 4, with out_data[i]=0x2A5 for all i.
  - done after edge 13.
- Clocks with periods 10/13/17/23/7/31/11/19 ns, cmd_mask=0x0D, data=0x155:
  - only domains 0, 2, 3 strobe, each once, with 0x155;
  - other out_data stay 0;
  - exactly one done pulse.
- cmd_mask=0x00, data=0x3FF: done pulses, no out_wr anywhere, cmd_ready returns to 1.
- cmd_valid held high while busy with data changing every cycle: only the first word is delivered, and the next transfer starts only after done.
- Two back-to-back commands 0x001 then 0x002: every selected domain sees out_wr twice, values in order, with no loss.
- rst pulsed low during S_REQ and again during S_REL:
  - all outputs return to reset values immediately;
  - no spurious out_wr after release;
  - the next command completes normally.
